// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART blocks.
//   - default frame geometry (OVERSAMPLE, DATA_BITS), also usable by tx_uart
//   - receiver FSM state encodings (2-bit, legacy-compatible localparams)
//   - helpers that derive the three oversample sample points from M = OS/2
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default oversampling ratio (ticks of clk_bps_os per bit) and payload width.
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // Receiver FSM encodings.
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    // Sample points around the bit centre M = os/2: ticks M-1, M and M+1.
    // The vote is resolved on the last one.
    function automatic int sample_first(input int os);
        return os / 2 - 1;
    endfunction

    function automatic int sample_mid(input int os);
        return os / 2;
    endfunction

    function automatic int sample_last(input int os);
        return os / 2 + 1;
    endfunction

    // Counter width that is never zero, so a 1-value counter still has a bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Front end of the UART receiver: synchronises the asynchronous serial line,
// detects the falling edge that opens a frame, counts oversample ticks within
// each bit and majority-votes three samples taken around the bit centre.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rs232_rx    raw serial line (idle high, asynchronous to clk)
//   clk_bps_os  one-clk pulse at OVERSAMPLE x baud
//   run         FSM is out of IDLE; the tick counter is held at 0 otherwise
//   fall_edge   synchronised 1 -> 0 transition of the line
//   bit_vote    majority of the three samples (valid with vote_stb)
//   vote_stb    this clk processes tick M+1 of the current bit
//   bit_end     this clk processes tick OVERSAMPLE-1 of the current bit
//
// OVERSAMPLE must be even and >= 8 so that M-1..M+1 fit inside one bit.
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    input  logic clk_bps_os,
    input  logic run,
    output logic fall_edge,
    output logic bit_vote,
    output logic vote_stb,
    output logic bit_end
);

    localparam int TW = cnt_width(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_FIRST = TW'(sample_first(OVERSAMPLE));
    localparam logic [TW-1:0] TICK_MID   = TW'(sample_mid(OVERSAMPLE));
    localparam logic [TW-1:0] TICK_VOTE  = TW'(sample_last(OVERSAMPLE));
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;     // [0] first stage, [1] synchronised value
    logic          rx_prev;    // synchronised value delayed by one clk
    logic [TW-1:0] tick_cnt;
    logic [1:0]    samples;    // captures from ticks M-1 and M
    logic          rx_sync;
    logic          tick_en;

    assign rx_sync = sync_q[1];
    assign tick_en = run & clk_bps_os;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // in this block sees the pre-edge value of its neighbours (the two sync
    // stages would collapse into one with blocking assignments).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle-high line: reset to 1 so release of reset is not a fall.
            sync_q   <= 2'b11;
            rx_prev  <= 1'b1;
            tick_cnt <= '0;
            samples  <= '0;
        end else begin
            sync_q  <= {sync_q[0], rs232_rx};
            rx_prev <= rx_sync;

            // Held at 0 while idle, so a frame always starts counting at tick 0
            // and ticks arriving in IDLE are ignored.
            if (!run) begin
                tick_cnt <= '0;
            end else if (clk_bps_os) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            end

            if (tick_en && tick_cnt == TICK_FIRST) samples[0] <= rx_sync;
            if (tick_en && tick_cnt == TICK_MID)   samples[1] <= rx_sync;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        fall_edge = 1'b0;
        vote_stb  = 1'b0;
        bit_end   = 1'b0;
        bit_vote  = 1'b1;

        // Edge, not level: a line that stays low never re-triggers.
        fall_edge = rx_prev & ~rx_sync;

        // The third sample is the live synchronised value on tick M+1, which
        // lets the vote resolve on the very clk that processes that tick.
        bit_vote = (samples[0] & samples[1]) |
                   (samples[0] & rx_sync)    |
                   (samples[1] & rx_sync);

        vote_stb = tick_en && (tick_cnt == TICK_VOTE);
        bit_end  = tick_en && (tick_cnt == TICK_LAST);
    end

endmodule : uart_rx_sampler

// File: rtl/rx_uart_os.sv
// -----------------------------------------------------------------------------
// rx_uart_os
// 8N1 (configurable DATA_BITS) UART receiver using an external 16x oversample
// tick. Validates the start bit, majority-votes every bit, checks the stop bit
// and presents each good byte on a valid/ready handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rs232_rx    serial line, idle high, asynchronous to clk
//   clk_bps_os  one-clk pulse at OVERSAMPLE x baud
//   rx_data     received byte; stable while rx_valid is high and not accepted
//   rx_valid    byte available; held until accepted
//   rx_ready    consumer accepts rx_data when rx_valid & rx_ready
//   rx_busy     high whenever the FSM is not in IDLE
//   frame_err   one-clk pulse when the stop bit votes 0 (byte discarded)
//   overrun     one-clk pulse when a good byte is dropped because the previous
//               one is still pending
// -----------------------------------------------------------------------------
module rx_uart_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232_rx,
    input  logic                 clk_bps_os,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    logic fall_edge;
    logic bit_vote;
    logic vote_stb;
    logic bit_end;

    logic stop_vote;
    logic good_frame;
    logic bad_frame;
    logic load_byte;
    logic accept;

    assign rx_busy = (state != RX_IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .clk_bps_os (clk_bps_os),
        .run        (rx_busy),
        .fall_edge  (fall_edge),
        .bit_vote   (bit_vote),
        .vote_stb   (vote_stb),
        .bit_end    (bit_end)
    );

    // ------------------------------------------------------------------
    // Frame FSM and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (fall_edge) begin
                        state   <= RX_START;
                        bit_cnt <= '0;
                    end
                end

                RX_START: begin
                    // A start bit that votes high was a glitch: abandon quietly.
                    if (vote_stb && bit_vote) begin
                        state <= RX_IDLE;
                    end else if (bit_end) begin
                        state   <= RX_DATA;
                        bit_cnt <= '0;
                    end
                end

                RX_DATA: begin
                    // Shift in at the MSB end: after DATA_BITS votes the first
                    // (LSB-first) bit has reached bit 0.
                    if (vote_stb) begin
                        shift_reg <= (shift_reg >> 1) |
                                     (DATA_BITS'(bit_vote) << (DATA_BITS - 1));
                    end
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            state   <= RX_STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                RX_STOP: begin
                    // Leave at the stop-bit centre rather than its end so the
                    // next start edge can follow immediately.
                    if (vote_stb) begin
                        state <= RX_IDLE;
                    end
                end

                default: state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output handshake and status pulses
    // ------------------------------------------------------------------
    assign stop_vote  = (state == RX_STOP) && vote_stb;
    assign good_frame = stop_vote &&  bit_vote;
    assign bad_frame  = stop_vote && !bit_vote;
    assign accept     = rx_valid && rx_ready;

    // A new byte may replace a pending one only if that one is being accepted
    // on this same edge; otherwise the held byte wins and the new one is lost.
    assign load_byte  = good_frame && (!rx_valid || rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_frame;
            overrun   <= good_frame && rx_valid && !rx_ready;

            if (load_byte) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule : rx_uart_os

// File: tb/tb_rx_uart_os.sv
// -----------------------------------------------------------------------------
// tb_rx_uart_os
// Drives serial frames with a bit-period-accurate line model, keeps a
// reference of what the receiver should deliver and compares through a
// scoreboard queue popped by an independent monitor.
// -----------------------------------------------------------------------------
module tb_rx_uart_os;

    localparam int OS      = 16;
    localparam int DB      = 8;
    localparam int M       = OS / 2;
    localparam int TICKDIV = 4;

    logic          clk;
    logic          rst_n;
    logic          rs232_rx;
    logic          clk_bps_os;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_busy;
    logic          frame_err;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DB-1:0] exp_q[$];
    bit            m_pending;
    bit            m_vote_now;
    bit            m_good;
    bit            m_exp_ovr;
    logic [DB-1:0] m_byte;
    int            exp_ferr_cnt = 0;
    int            exp_ovr_cnt  = 0;
    int            act_ferr_cnt = 0;
    int            act_ovr_cnt  = 0;
    bit            rand_ready_en;

    // Latency observation
    int tick_idx  = 0;
    int rise_idx  = -1;
    bit busy_seen = 1'b0;
    bit valid_q   = 1'b0;

    rx_uart_os #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .clk_bps_os (clk_bps_os),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int div;
        div = 0;
        clk_bps_os = 1'b0;
        forever begin
            @(negedge clk);
            div++;
            clk_bps_os = (div % TICKDIV == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) rx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the output buffer: a good frame lands if the
    // buffer is empty or being drained on that clk; otherwise it is lost.
    always @(posedge clk) begin
        bit vote;
        vote      = m_vote_now && clk_bps_os;
        m_exp_ovr = 1'b0;
        if (rst_n) begin
            if (vote && !m_good) exp_ferr_cnt++;
            if (vote && m_good && (!m_pending || rx_ready)) begin
                exp_q.push_back(m_byte);
                m_pending = 1'b1;
            end else begin
                if (vote && m_good) begin
                    m_exp_ovr = 1'b1;
                    exp_ovr_cnt++;
                end
                if (m_pending && rx_ready) m_pending = 1'b0;
            end
            if (clk_bps_os && busy_seen) tick_idx++;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        check("rx_valid_vs_model", rx_valid, m_pending);
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
            end else begin
                check("rx_data", rx_data, exp_q.pop_front());
            end
        end
        if (frame_err) act_ferr_cnt++;
        if (overrun)   act_ovr_cnt++;
        if (rx_valid && !valid_q) rise_idx = tick_idx - 1;
        valid_q = rx_valid;
        if (rx_busy && !busy_seen) tick_idx = 0;
        busy_seen = rx_busy;
    end

    task automatic next_tick();
        do @(posedge clk); while (!clk_bps_os);
        #1;
    endtask

    // Drive n_bits of a frame (start, data LSB first, stop). One bit lasts OS
    // tick periods; an optional single-tick inversion can be placed anywhere.
    task automatic send_frame(input logic [DB-1:0] data, input logic stop,
                              input int g_bit, input int g_tick,
                              input int n_bits, input bit ready_pulse);
        logic [DB+1:0] frame;
        logic lvl;
        frame  = {stop, data, 1'b0};
        m_byte = data;
        for (int b = 0; b < n_bits; b++) begin
            for (int t = 0; t < OS; t++) begin
                lvl = frame[b];
                if (b == g_bit && t == g_tick) lvl = ~lvl;
                rs232_rx = lvl;
                if (b == DB + 1 && t == M + 1) begin
                    m_good     = stop;
                    m_vote_now = 1'b1;
                    if (ready_pulse) begin
                        repeat (TICKDIV - 1) @(posedge clk);
                        #1 rx_ready = 1'b1;
                    end
                    next_tick();
                    m_vote_now = 1'b0;
                    if (ready_pulse) rx_ready = 1'b0;
                    check("frame_err_at_vote", frame_err, !stop);
                    check("overrun_at_vote", overrun, m_exp_ovr);
                end else begin
                    next_tick();
                end
            end
        end
    endtask

    initial begin
        logic [DB-1:0] d;
        logic          s;
        int            gb;
        int            gt;

        rst_n = 1'b0; rs232_rx = 1'b1; rx_ready = 1'b0;
        m_pending = 0; m_vote_now = 0; m_good = 0; rand_ready_en = 0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (4) next_tick();

        // 0x55 with consumer ready: latency and data
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b1, -1, 0, DB + 2, 1'b0);
        repeat (2) next_tick();
        check("latency_tick_index", rise_idx, 153);
        check("rx_data_55", rx_data, 8'h55);
        check("busy_after_55", rx_busy, 0);

        // Two-tick low glitch: false start
        rs232_rx = 1'b0;
        next_tick();
        check("busy_in_false_start", rx_busy, 1);
        next_tick();
        rs232_rx = 1'b1;
        repeat (M) next_tick();
        check("busy_after_false_start", rx_busy, 0);
        repeat (6) next_tick();

        // 0xA3 with bad stop, line then held low (no retrigger)
        send_frame(8'hA3, 1'b0, -1, 0, DB + 2, 1'b0);
        repeat (40) next_tick();
        check("busy_line_stuck_low", rx_busy, 0);
        check("frame_err_count", act_ferr_cnt, 1);
        rs232_rx = 1'b1;
        repeat (4) next_tick();

        // 0x11 then 0x22 back-to-back, consumer stalled: overrun on 0x22
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, 0, DB + 2, 1'b0);
        send_frame(8'h22, 1'b1, -1, 0, DB + 2, 1'b0);
        check("held_rx_data_11", rx_data, 8'h11);
        check("held_rx_valid", rx_valid, 1);
        check("overrun_count", act_ovr_cnt, 1);
        rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("valid_cleared", rx_valid, 0);
        rx_ready = 1'b0;
        next_tick();

        // 0x3C pending, ready pulsed exactly on the 0x7E stop-vote clk
        send_frame(8'h3C, 1'b1, -1, 0, DB + 2, 1'b0);
        send_frame(8'h7E, 1'b1, -1, 0, DB + 2, 1'b1);
        check("rx_data_7e", rx_data, 8'h7E);
        check("rx_valid_7e", rx_valid, 1);
        rx_ready = 1'b1;
        next_tick();
        rx_ready = 1'b0;

        // 0xF0 with an inverted sample at tick M of data bit 2
        send_frame(8'hF0, 1'b1, 3, M, DB + 2, 1'b0);
        check("rx_data_f0_glitch", rx_data, 8'hF0);
        check("rx_valid_f0", rx_valid, 1);

        // Reset in the middle of a frame
        send_frame(8'h5A, 1'b1, -1, 0, 4, 1'b0);
        check("busy_mid_frame", rx_busy, 1);
        rst_n = 1'b0; rs232_rx = 1'b1;
        m_pending = 1'b0; exp_q.delete();
        #1;
        check("midreset_rx_data", rx_data, 0);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_rx_busy", rx_busy, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) next_tick();
        check("after_reset_busy", rx_busy, 0);

        // Randomised frames with a randomly stalling consumer
        rand_ready_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d  = DB'($urandom);
            s  = ($urandom_range(0, 5) != 0);
            gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DB)) : -1;
            gt = int'($urandom_range(1, OS - 2));
            send_frame(d, s, gb, gt, DB + 2, 1'b0);
            rs232_rx = 1'b1;
            repeat (1 + $urandom_range(0, 3)) next_tick();
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2 rx_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("final_valid", rx_valid, 0);
        check("frame_err_total", act_ferr_cnt, exp_ferr_cnt);
        check("overrun_total", act_ovr_cnt, exp_ovr_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rx_uart_os

// File: doc/rx_uart_os.md
Name: rx_uart_os

Overview:
- 8N1 UART receiver, the receive-side counterpart of the team's tx_uart.
- Samples the asynchronous rs232_rx line using an external oversampling tick (16x baud), validates the start bit, majority-votes each bit and checks the stop bit.
- Presents each received byte on a valid/ready handshake with overrun and framing-error flags.
- Sits between the board RX pin and the command/byte-parsing logic.

Parameters:
OVERSAMPLE, 16, ticks of clk_bps_os per bit; must be even and >= 8
DATA_BITS, 8, payload bits per frame, LSB first

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
rs232_rx  in  1  serial line, idle high, asynchronous to clk
clk_bps_os  in  1  one-clk-wide pulse at OVERSAMPLE x baud rate
rx_data  out  DATA_BITS  received byte; stable while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
rx_busy  out  1  high in any state other than IDLE
frame_err  out  1  one-clk pulse when the stop bit votes 0
overrun  out  1  one-clk pulse when a good frame is dropped

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, both synchroniser flops=1, state=IDLE, all counters=0.
- Input: 2-flop synchroniser, then a 1-flop delayed copy for edge detection. All decisions use the synchronised value.
- Counters: tick_cnt counts 0..OVERSAMPLE-1 and advances only on clk_bps_os; bit_cnt counts 0..DATA_BITS-1.
- Sample points: M=OVERSAMPLE/2. On ticks M-1, M and M+1 the line is captured into 3 sample regs. The vote (majority of 3) is resolved on the clk that processes tick M+1.
- IDLE:
  - A synchronised falling edge (prev=1, now=0) moves to START with tick_cnt=0 and rx_busy=1.
  - There is no edge detection while the line stays low, so a break or a stuck-low line is never re-triggered.
- START:
  - Vote=1: false start; go to IDLE immediately with no flags.
  - Vote=0: continue counting; at tick OVERSAMPLE-1 go to DATA with bit_cnt=0.
- DATA:
  - Each vote is shifted into a shift register at the MSB end, giving LSB-first assembly.
  - At tick OVERSAMPLE-1, bit_cnt increments. After bit DATA_BITS-1, go to STOP.
- STOP (vote clk, i.e. tick M+1):
  - Vote=1 (good frame): deliver the byte; go to IDLE on the same edge. Returning before the stop bit ends allows back-to-back frames.
  - Vote=0: frame_err pulses for 1 clk; the byte is discarded; go to IDLE.
- Delivery on a good frame:
  - rx_valid=0, or rx_valid=1 & rx_ready=1 on that clk: load rx_data and set rx_valid=1. The old byte is consumed; there is no overrun.
  - rx_valid=1 & rx_ready=0: overrun pulses for 1 clk; rx_data keeps the old byte and the new byte is lost.
- Handshake:
  - rx_valid clears on the edge where rx_valid & rx_ready, unless a new byte loads on that same edge.
  - rx_data must not change while rx_valid=1 and not accepted.
- Latency: rx_valid rises on the clk edge that processes stop-bit tick M+1. For OVERSAMPLE=16 that is tick 9+16x9=153 after the start-edge detection.
- Ticks: a clk_bps_os pulse that arrives while in IDLE is ignored.
- Reset mid-frame: everything returns to reset values immediately, with no flag pulses. A partial frame is lost.

Decomposition:
- Shared header/package uart_pkg:
  - state encodings RX_IDLE, RX_START, RX_DATA, RX_STOP (2-bit);
  - default OVERSAMPLE, DATA_BITS;
  - sample-index constants derived from M.
- tx_uart can adopt DATA_BITS from the same package.
- One natural sub-module: uart_rx_sampler.
  - Contents: the synchroniser, edge detect, tick counter, 3-sample capture and majority vote.
  - Outputs to the FSM: fall_edge, bit_vote, vote_stb and bit_end.
  - rx_uart_os keeps the FSM, the shift register and the output handshake.

Test Plan:
- Bench setup: clk_bps_os pulses every 4 clk.
- Byte 0x55 (frame 0,1,0,1,0,1,0,1,0,1), rx_ready=1 -> rx_valid rises 153 ticks after the edge; rx_data=0x55; frame_err=0, overrun=0.
- 2-tick low glitch then idle -> START vote=1; back to IDLE; no rx_valid or frame_err; rx_busy drops by tick 9.
- Frame 0xA3 with stop bit forced 0 -> frame_err pulses once; rx_valid stays 0; line held low afterwards -> no new frame detected.
- 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 held; overrun pulses at 0x22's stop vote. Then rx_ready=1 -> rx_valid clears.
- 0x3C pending with rx_ready pulsed exactly on the 0x7E stop-vote clk -> rx_data=0x7E, rx_valid stays 1, overrun=0.
- Single-tick inversion at tick 8 of data bit 2 of 0xF0 -> majority vote rejects it; rx_data=0xF0. Then rst_n low mid-byte -> all outputs 0, state IDLE.
